// File: rtl/jtopl_lfo.sv
// OPL2 low-frequency oscillator: vibrato step counter and tremolo attenuation.
// Optional macro JTOPL_LFO_TEST_EN: lfo_test=1 makes every frame step both LFOs.
module jtopl_lfo #(
   parameter int VIB_LOG2 = 10,
   parameter int AM_LOG2  = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       zero,
   input  logic       am_dep,
   input  logic       lfo_test,
   output logic [2:0] vib_cnt,
   output logic [4:0] trem
);

   localparam int TW = (VIB_LOG2 > AM_LOG2) ? VIB_LOG2 : AM_LOG2;

   logic [TW-1:0] timer;
   logic [7:0]    am_pos;
   logic          fr;
   logic          vib_step;
   logic          am_step;
   logic [6:0]    tri_lvl;
   logic [4:0]    trem_nx;

   assign fr = cen & zero;

`ifdef JTOPL_LFO_TEST_EN
   assign vib_step = fr & (lfo_test | (&timer[VIB_LOG2-1:0]));
   assign am_step  = fr & (lfo_test | (&timer[AM_LOG2-1:0]));
`else
   logic unused_lfo_test;
   assign unused_lfo_test = lfo_test;
   assign vib_step = fr & (&timer[VIB_LOG2-1:0]);
   assign am_step  = fr & (&timer[AM_LOG2-1:0]);
`endif

   // am_pos folds into a 0..105..0 triangle over its 210-step period
   always_comb begin
      tri_lvl = 7'd0;
      if (am_pos < 8'd105)
         tri_lvl = am_pos[6:0];
      else
         tri_lvl = 7'(8'd210 - am_pos);
      trem_nx = am_dep ? 5'(tri_lvl >> 2) : 5'(tri_lvl >> 4);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= '0;
         vib_cnt <= '0;
         am_pos  <= '0;
         trem    <= '0;
      end else if (cen) begin
         trem <= trem_nx;
         if (fr)
            timer <= timer + 1'b1;
         if (vib_step)
            vib_cnt <= vib_cnt + 3'd1;
         if (am_step)
            am_pos <= (am_pos == 8'd209) ? 8'd0 : am_pos + 8'd1;
      end
   end

endmodule
